// File: rtl/sata_oob_pkg.sv
// sata_oob_pkg: state encodings and sizing helper shared by
// the host-side SATA OOB link-initialisation sequencer.
package sata_oob_pkg;

  localparam int STATE_W = 4;

  localparam logic [3:0] ST_RESET            = 4'd0;
  localparam logic [3:0] ST_COMRESET         = 4'd1;
  localparam logic [3:0] ST_AWAIT_COMINIT    = 4'd2;
  localparam logic [3:0] ST_AWAIT_NO_COMINIT = 4'd3;
  localparam logic [3:0] ST_COMWAKE          = 4'd4;
  localparam logic [3:0] ST_AWAIT_COMWAKE    = 4'd5;
  localparam logic [3:0] ST_AWAIT_NO_COMWAKE = 4'd6;
  localparam logic [3:0] ST_AWAIT_ALIGN      = 4'd7;
  localparam logic [3:0] ST_SEND_ALIGN       = 4'd8;
  localparam logic [3:0] ST_READY            = 4'd9;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// sata_oob_timer: clear/enable saturating up-counter with a
// terminal-value compare, shared by state timeouts and idle-loss.
module sata_oob_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/sata_host_oob_ctrl.sv
// sata_host_oob_ctrl: host SATA OOB sequencer, COMRESET to ALIGN lock.
// Define SATA_OOB_STATS_EN to add retry_cnt/loss_cnt outputs.
module sata_host_oob_ctrl
  import sata_oob_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int RETRY_CYC   = 1_000_000,
  parameter int ALIGN_CYC   = 87_380,
  parameter int LOSS_CYC    = 1_024
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         restart,
  output logic         tx_cominit,
  output logic         tx_comwake,
  input  logic         tx_comfinish,
  output logic         tx_elecidle,
  output logic         tx_d102,
  output logic         tx_align,
  input  logic         rx_cominit_det,
  input  logic         rx_comwake_det,
  input  logic         rx_align_det,
  input  logic         rx_sync_det,
  input  logic         rx_idle,
  output logic         link_up,
  output logic [3:0]   state_o
`ifdef SATA_OOB_STATS_EN
  ,
  output logic [15:0]  retry_cnt,
  output logic [15:0]  loss_cnt
`endif
);

  localparam int TMR_W =
    $clog2(max3(RETRY_CYC, ALIGN_CYC, LOSS_CYC) + 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt;
  logic [TMR_W-1:0]   tmr_term;
  logic               tmr_hit;
  logic               tmr_clr;
  logic               tmr_en;
  logic               loss;
  logic               enter_cr;
  logic               lane_on;

  // In READY the timer counts consecutive idle cycles only
  assign tmr_en  = (state != ST_READY) || rx_idle;
  assign tmr_clr = (nxt != state) || restart ||
                   ((state == ST_READY) && !rx_idle);
  assign loss    = tmr_hit && rx_idle;

  always_comb begin
    tmr_term = TMR_W'(RETRY_CYC - 1);
    unique case (1'b1)
      state == ST_AWAIT_ALIGN: tmr_term = TMR_W'(ALIGN_CYC - 1);
      state == ST_READY:       tmr_term = TMR_W'(LOSS_CYC - 1);
      default:                 tmr_term = TMR_W'(RETRY_CYC - 1);
    endcase
  end

  sata_oob_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .hit   (tmr_hit)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_RESET: nxt = ST_COMRESET;
      ST_COMRESET:
        if (tx_comfinish) nxt = ST_AWAIT_COMINIT;
      ST_AWAIT_COMINIT:
        if (rx_cominit_det) nxt = ST_AWAIT_NO_COMINIT;
        else if (tmr_hit)   nxt = ST_COMRESET;
      ST_AWAIT_NO_COMINIT:
        if (!rx_cominit_det) nxt = ST_COMWAKE;
      ST_COMWAKE:
        if (tx_comfinish) nxt = ST_AWAIT_COMWAKE;
      ST_AWAIT_COMWAKE:
        if (rx_comwake_det) nxt = ST_AWAIT_NO_COMWAKE;
        else if (tmr_hit)   nxt = ST_COMRESET;
      ST_AWAIT_NO_COMWAKE:
        if (!rx_comwake_det) nxt = ST_AWAIT_ALIGN;
      ST_AWAIT_ALIGN:
        if (rx_align_det) nxt = ST_SEND_ALIGN;
        else if (tmr_hit) nxt = ST_COMRESET;
      ST_SEND_ALIGN:
        if (rx_sync_det) nxt = ST_READY;
      ST_READY:
        if (rx_cominit_det || loss) nxt = ST_COMRESET;
      default: nxt = ST_RESET;
    endcase
    if (restart) nxt = ST_COMRESET;
  end

  // A restart while already in COMRESET re-issues the burst
  assign enter_cr = (nxt == ST_COMRESET) &&
                    ((state != ST_COMRESET) || restart);
  assign lane_on  = (nxt == ST_AWAIT_ALIGN) ||
                    (nxt == ST_SEND_ALIGN) ||
                    (nxt == ST_READY);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_RESET;
      tx_cominit  <= 1'b0;
      tx_comwake  <= 1'b0;
      tx_elecidle <= 1'b1;
      tx_d102     <= 1'b0;
      tx_align    <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      state       <= nxt;
      tx_cominit  <= enter_cr;
      tx_comwake  <= (nxt == ST_COMWAKE) &&
                     (state != ST_COMWAKE);
      tx_elecidle <= !lane_on;
      tx_d102     <= (nxt == ST_AWAIT_ALIGN);
      tx_align    <= (nxt == ST_SEND_ALIGN);
      link_up     <= (nxt == ST_READY);
    end
  end

  assign state_o = state;

`ifdef SATA_OOB_STATS_EN
  logic tmo;

  assign tmo = !restart && (nxt == ST_COMRESET) &&
               ((state == ST_AWAIT_COMINIT) ||
                (state == ST_AWAIT_COMWAKE) ||
                (state == ST_AWAIT_ALIGN));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else if (restart) begin
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      if (tmo && (retry_cnt != 16'hFFFF))
        retry_cnt <= retry_cnt + 1'b1;
      if ((state == ST_READY) && (nxt == ST_COMRESET) &&
          (loss_cnt != 16'hFFFF))
        loss_cnt <= loss_cnt + 1'b1;
    end
  end
`endif

endmodule
